// File: rtl/rx_fcs_strip.sv
// rx_fcs_strip: checks and strips the Ethernet FCS, flags bad frames on tuser with the last payload byte.
module rx_fcs_strip #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  FCSi_tdata,
  input  logic        FCSi_tlast,
  input  logic        FCSi_tuser,
  input  logic        FCSi_tvalid,
  output logic        FCSi_tready,
  output logic [7:0]  FCSo_tdata,
  output logic        FCSo_tlast,
  output logic        FCSo_tuser,
  output logic        FCSo_tvalid,
  input  logic        FCSo_tready,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);
  typedef enum logic {FILL, PASS} state_t;
  state_t state;
  logic [3:0][7:0] dl;
  logic [31:0] crc, crc_n;
  logic [10:0] bcnt, bcnt_n;
  logic phy, phy_n, acc, bad;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign FCSi_tready = !FCSo_tvalid | FCSo_tready;
  assign acc         = FCSi_tvalid & FCSi_tready;
  assign crc_n       = crc8(crc, FCSi_tdata);
  assign bcnt_n      = (bcnt == 11'h7ff) ? bcnt : bcnt + 11'd1;
  assign phy_n       = phy | FCSi_tuser;
  // residue after the FCS bytes is the fixed 802.3 magic value when the frame is intact
  assign bad         = (crc_n != 32'hDEBB20E3) | (int'(bcnt_n) < MIN_LEN) | (int'(bcnt_n) > MAX_LEN) | phy_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FILL;
      dl          <= '0;
      crc         <= 32'hFFFFFFFF;
      bcnt        <= '0;
      phy         <= 1'b0;
      FCSo_tdata  <= '0;
      FCSo_tlast  <= 1'b0;
      FCSo_tuser  <= 1'b0;
      FCSo_tvalid <= 1'b0;
      frames_ok   <= '0;
      frames_bad  <= '0;
    end else begin
      if (FCSo_tready) FCSo_tvalid <= 1'b0;
      if (acc) begin
        dl <= {dl[2:0], FCSi_tdata};
        if (state == PASS) begin
          FCSo_tvalid <= 1'b1;
          FCSo_tdata  <= dl[3];
          FCSo_tlast  <= FCSi_tlast;
          FCSo_tuser  <= FCSi_tlast & bad;
        end
        if (FCSi_tlast) begin
          state <= FILL;
          dl    <= '0;
          crc   <= 32'hFFFFFFFF;
          bcnt  <= '0;
          phy   <= 1'b0;
          if (bad) frames_bad <= frames_bad + 16'd1;
          else     frames_ok  <= frames_ok + 16'd1;
        end else begin
          crc  <= crc_n;
          bcnt <= bcnt_n;
          phy  <= phy_n;
          if (bcnt == 11'd3) state <= PASS;
        end
      end
    end
  end
endmodule

// File: tb/tb_rx_fcs_strip.sv
// tb_rx_fcs_strip: directed frames with bench-computed FCS, checked against expected payload beats.
module tb_rx_fcs_strip;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] FCSi_tdata = '0;
  logic FCSi_tlast = 1'b0, FCSi_tuser = 1'b0, FCSi_tvalid = 1'b0, FCSo_tready = 1'b1;
  logic FCSi_tready, FCSo_tlast, FCSo_tuser, FCSo_tvalid;
  logic [7:0] FCSo_tdata;
  logic [15:0] frames_ok, frames_bad;
  int total = 0, bad = 0;
  bit rnd = 1'b0;
  logic [7:0] fr[$];
  logic [9:0] outq[$], expq[$];

  always #5 clk = ~clk;

  rx_fcs_strip dut (
    .clk(clk), .rst(rst),
    .FCSi_tdata(FCSi_tdata), .FCSi_tlast(FCSi_tlast), .FCSi_tuser(FCSi_tuser),
    .FCSi_tvalid(FCSi_tvalid), .FCSi_tready(FCSi_tready),
    .FCSo_tdata(FCSo_tdata), .FCSo_tlast(FCSo_tlast), .FCSo_tuser(FCSo_tuser),
    .FCSo_tvalid(FCSo_tvalid), .FCSo_tready(FCSo_tready),
    .frames_ok(frames_ok), .frames_bad(frames_bad)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  task automatic mk(input int len, input int seed, input int flip);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < len - 4; i++) fr.push_back(8'((seed + i * 13) & 255));
    c = 32'hFFFFFFFF;
    foreach (fr[i]) c = crc8(c, fr[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
    if (flip >= 0) fr[flip] = fr[flip] ^ 8'h01;
  endtask

  task automatic add_exp(input logic b);
    int n;
    n = fr.size();
    for (int i = 0; i < n - 4; i++) expq.push_back({(i == n - 5) & b, i == n - 5, fr[i]});
  endtask

  task automatic send(input int uidx, input int nb);
    logic a;
    int t;
    for (int i = 0; i < nb; i++) begin
      if (rnd) while ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      FCSi_tvalid = 1'b1;
      FCSi_tdata  = fr[i];
      FCSi_tlast  = (i == fr.size() - 1);
      FCSi_tuser  = (i == uidx);
      t = 0;
      do begin
        @(negedge clk);
        a = FCSi_tready;
        @(posedge clk);
        #1;
        t++;
      end while (!a && t < 1000);
      chk("accept", {31'd0, a}, 32'd1);
      FCSi_tvalid = 1'b0;
      FCSi_tlast  = 1'b0;
      FCSi_tuser  = 1'b0;
    end
  endtask

  task automatic check(input string name, input int ok, input int nbad);
    int t, n;
    t = 0;
    while (outq.size() < expq.size() && t < 5000) begin @(posedge clk); t++; end
    repeat (8) @(posedge clk);
    #1;
    chk({name, "_beats"}, outq.size(), expq.size());
    n = (outq.size() < expq.size()) ? outq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_data"}, {24'd0, outq[i][7:0]}, {24'd0, expq[i][7:0]});
      chk({name, "_last"}, {31'd0, outq[i][8]}, {31'd0, expq[i][8]});
      if (expq[i][8]) chk({name, "_user"}, {31'd0, outq[i][9]}, {31'd0, expq[i][9]});
    end
    chk({name, "_ok"}, {16'd0, frames_ok}, ok);
    chk({name, "_bad"}, {16'd0, frames_bad}, nbad);
    outq.delete();
    expq.delete();
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    FCSo_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    logic pv = 1'b0, pr = 1'b0;
    logic [9:0] pd = '0;
    forever begin
      @(negedge clk);
      if (rst && pv && !pr) chk("hold", {21'd0, FCSo_tvalid, FCSo_tuser, FCSo_tlast, FCSo_tdata}, {21'd0, 1'b1, pd});
      if (FCSo_tvalid && FCSo_tready) outq.push_back({FCSo_tuser, FCSo_tlast, FCSo_tdata});
      pv = FCSo_tvalid;
      pr = FCSo_tready;
      pd = {FCSo_tuser, FCSo_tlast, FCSo_tdata};
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {20'd0, FCSo_tvalid, FCSo_tlast, FCSo_tuser, 1'b0, FCSo_tdata}, 32'd0);
    chk("rst_cnt", {frames_ok, frames_bad}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, FCSi_tready}, 32'd1);
    mk(64, 1, -1);   add_exp(1'b0); send(-1, fr.size()); check("good64", 1, 0);
    mk(64, 2, 9);    add_exp(1'b1); send(-1, fr.size()); check("crc64", 1, 1);
    mk(10, 3, -1);   add_exp(1'b1); send(-1, fr.size()); check("runt10", 1, 2);
    fr = '{8'h11, 8'h22, 8'h33};    send(-1, fr.size()); check("len3", 1, 3);
    mk(4, 4, -1);                   send(-1, fr.size()); check("len4", 1, 4);
    mk(64, 5, -1);   add_exp(1'b1); send(19, fr.size()); check("phy64", 1, 5);
    mk(1530, 6, -1); add_exp(1'b1); send(-1, fr.size()); check("giant", 1, 6);
    mk(63, 7, -1);   add_exp(1'b1); send(-1, fr.size()); check("len63", 1, 7);
    mk(1522, 8, -1); add_exp(1'b0); send(-1, fr.size()); check("max1522", 2, 7);
    rnd = 1'b1;
    mk(64, 9, -1);   add_exp(1'b0); send(-1, fr.size());
    mk(64, 10, 9);   add_exp(1'b1); send(-1, fr.size());
    mk(10, 11, -1);  add_exp(1'b1); send(-1, fr.size());
    check("stall", 3, 9);
    rnd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mk(64, 12, -1);
    send(-1, 30);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_out", {31'd0, FCSo_tvalid}, 32'd0);
    chk("midrst_cnt", {frames_ok, frames_bad}, 32'd0);
    rst = 1'b1;
    outq.delete();
    expq.delete();
    @(posedge clk);
    #1;
    mk(64, 13, -1);  add_exp(1'b0); send(-1, fr.size()); check("after_rst", 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rx_fcs_strip.md
RX_FCS_STRIP -- requirements
Module: rx_fcs_strip

Upstream receive stage: checks and strips the Ethernet FCS, then feeds L23_buffer with a frame-error flag on tuser.

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, meaning the minimum good frame length in bytes, FCS included.
REQ-002 SHALL have parameter MAX_LEN, default 1522, meaning the maximum good frame length in bytes, FCS included.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- FCSi_tdata  in  8  input frame byte.
- FCSi_tlast  in  1  last byte of frame (last FCS byte).
- FCSi_tuser  in  1  upstream PHY error on this beat.
- FCSi_tvalid  in  1  input beat valid.
- FCSi_tready  out  1  block accepts input beat.
- FCSo_tdata  out  8  output frame byte, FCS removed.
- FCSo_tlast  out  1  last payload byte of frame.
- FCSo_tuser  out  1  frame bad; meaningful only with FCSo_tlast.
- FCSo_tvalid  out  1  output beat valid.
- FCSo_tready  in  1  downstream accepts beat.
- frames_ok  out  16  count of frames delivered with tuser=0.
- frames_bad  out  16  count of frames flagged or discarded.

Function
REQ-004 An input beat SHALL be accepted only on a clk edge with FCSi_tvalid=1 and FCSi_tready=1; an output beat SHALL transfer only with FCSo_tvalid=1 and FCSo_tready=1.
REQ-005 The output SHALL be a single register stage, and FCSi_tready SHALL equal (!FCSo_tvalid | FCSo_tready), combinational.
REQ-006 Once FCSo_tvalid=1, FCSo_tdata/tlast/tuser SHALL hold stable until the output beat transfers.
REQ-007 A 4-byte delay line SHALL hold the newest 4 accepted bytes of the current frame.
REQ-008 The frame FSM SHALL have two states:
- FILL: fewer than 4 bytes held.
- PASS: 4 bytes held; each accepted byte shifts the oldest held byte into the output register.
REQ-009 Transitions SHALL be: FILL->PASS on accepting the 4th byte without tlast; any state->FILL on accepting a tlast beat (delay line cleared).
REQ-010 In PASS, accepting a tlast beat SHALL load the output register with the oldest held byte plus FCSo_tlast=1 and FCSo_tuser=bad, where bad = crc_err | len_err | phy_err.
REQ-011 Frames of total length <=4 SHALL produce no output beat, and SHALL increment frames_bad on the tlast beat.
REQ-012 Output latency SHALL be: a byte accepted at input position k (k>=1) appears at output after acceptance of byte k+4, one clock later.
REQ-013 CRC SHALL be CRC-32 IEEE 802.3: reflected polynomial 0xEDB88320, LSB first, register initialised to 0xFFFFFFFF at frame start, updated over every accepted byte including the FCS bytes.
REQ-014 crc_err SHALL be 1 when the register value after the tlast byte is not 0xDEBB20E3 (no final inversion).
REQ-015 An 11-bit byte counter SHALL count frame bytes, saturating at 2047.
REQ-016 len_err SHALL be 1 when the count including the tlast byte is < MIN_LEN or > MAX_LEN.
REQ-017 phy_err SHALL be 1 when FCSi_tuser=1 on any accepted beat of the frame, the tlast beat included; it is sticky until frame end.
REQ-018 frames_ok and frames_bad SHALL increment on acceptance of each tlast beat, per bad, and SHALL wrap at 0xFFFF.
REQ-019 A tlast beat accepted while the previous tlast output beat is still pending SHALL be legal: REQ-005 stalls the input until space exists, and no byte SHALL be lost or reordered.

Reset
REQ-020 While rst=0, all outputs and counters SHALL be 0, and the FSM, delay line and byte counter SHALL be in FILL/empty; the CRC register SHALL be 0xFFFFFFFF.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame; the first beat after rst=1 SHALL be treated as a new frame start.
REQ-022 FCSi_tready SHALL be 1 in the first cycle after reset release.

Verification
REQ-023 Valid 64-byte frame with correct FCS, tready=1 -> 60 output bytes, FCSo_tlast on byte 60, FCSo_tuser=0, frames_ok=1.
REQ-024 Same frame with byte 10 XOR 0x01 -> 60 bytes out, FCSo_tuser=1 on the last byte, frames_bad=1.
REQ-025 10-byte frame with correct FCS -> 6 bytes out, tuser=1 (runt); 3-byte frame -> no output beats, frames_bad+1.
REQ-026 Valid 64-byte frame with FCSi_tuser=1 on byte 20 -> tuser=1 on last; 1530-byte valid frame -> tuser=1 (giant).
REQ-027 Back-to-back frames with random tvalid/tready at 50% -> output byte sequence identical to the no-stall run, holding stable during stalls.
REQ-028 rst=0 pulsed at byte 30 of a frame, then a valid 64-byte frame sent -> only the second frame appears, frames_ok=1.
